// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// uart_rx_ctrl: receiver enable/baud sequencing, RX byte FIFO, saturating error
// counters. Optional macro UART_RX_CTRL_ERRFLAG_EN keeps errored bytes. Rev 1.0
// ============================================================================
module uart_rx_ctrl #(
    parameter int         DEPTH          = 8,
    parameter int         QUIESCE_CYCLES = 16,
    parameter logic [2:0] BAUD_DEFAULT   = 3'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     cfg_baud_req,
    input  logic [2:0]               cfg_baud,
    output logic                     cfg_baud_ack,
    output logic                     rx_en,
    output logic [2:0]               baud_select,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ferror,
    input  logic                     rx_perror,
`ifdef UART_RX_CTRL_ERRFLAG_EN
    output logic [1:0]               out_err,
`endif
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               ferror_cnt,
    output logic [7:0]               perror_cnt,
    output logic [7:0]               ovf_cnt
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
`ifdef UART_RX_CTRL_ERRFLAG_EN
    localparam int c_dw = 10;
`else
    localparam int c_dw = 8;
`endif
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [15:0]        c_quiesce = 16'(QUIESCE_CYCLES);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_qcnt, w_qcnt_next;
    logic        r_rx_en, r_ack;
    logic [2:0]  r_baud;

    always_comb begin
        w_state_next = r_state;
        w_qcnt_next  = r_qcnt;
        case (r_state)
            ST_OFF: begin
                if (enable) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_next = ST_OFF;
                end else if (cfg_baud_req) begin
                    w_state_next = ST_DRAIN;
                    w_qcnt_next  = c_quiesce;
                end
            end
            ST_DRAIN: begin
                if (r_qcnt <= 16'd1) w_state_next = ST_SWITCH;
                else                 w_qcnt_next  = r_qcnt - 16'd1;
            end
            ST_SWITCH: begin
                w_state_next = enable ? ST_RUN : ST_OFF;
            end
            default: w_state_next = ST_OFF;
        endcase
    end

    // rx_en and the ack trail the state by one cycle; the ack lands with the new baud
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_OFF;
            r_qcnt  <= 16'd0;
            r_rx_en <= 1'b0;
            r_ack   <= 1'b0;
            r_baud  <= BAUD_DEFAULT;
        end else begin
            r_state <= w_state_next;
            r_qcnt  <= w_qcnt_next;
            r_rx_en <= (r_state == ST_RUN);
            r_ack   <= (r_state == ST_SWITCH);
            if (r_state == ST_SWITCH) r_baud <= cfg_baud;
        end
    end

    assign rx_en        = r_rx_en;
    assign cfg_baud_ack = r_ack;
    assign baud_select  = r_baud;

    logic               r_valid_d;
    logic [7:0]         r_ferr, r_perr, r_ovf;
    logic [c_dw-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_capture, w_push, w_pop, w_full, w_push_ok, w_ovf;
    logic [c_dw-1:0]    w_wdata;

    assign w_capture = rx_valid & ~r_valid_d;
`ifdef UART_RX_CTRL_ERRFLAG_EN
    assign w_push  = w_capture;
    assign w_wdata = {rx_perror, rx_ferror, rx_data};
`else
    assign w_push  = w_capture & ~rx_ferror & ~rx_perror;
    assign w_wdata = rx_data;
`endif
    assign out_valid = (r_count != '0);
    assign w_full    = (r_count == c_full);
    assign w_pop     = out_valid & out_ready;
    // a full FIFO still accepts a byte when the head leaves in the same cycle
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ovf     = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_wdata;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_d <= 1'b0;
            r_ferr    <= 8'd0;
            r_perr    <= 8'd0;
            r_ovf     <= 8'd0;
        end else begin
            r_valid_d <= rx_valid;
            if (w_capture && rx_ferror && (r_ferr != 8'hFF)) r_ferr <= r_ferr + 8'd1;
            if (w_capture && rx_perror && (r_perr != 8'hFF)) r_perr <= r_perr + 8'd1;
            if (w_ovf && (r_ovf != 8'hFF))                   r_ovf  <= r_ovf + 8'd1;
        end
    end

    assign out_data   = r_mem[r_rd_ptr][7:0];
`ifdef UART_RX_CTRL_ERRFLAG_EN
    assign out_err    = r_mem[r_rd_ptr][9:8];
`endif
    assign fifo_count = r_count;
    assign ferror_cnt = r_ferr;
    assign perror_cnt = r_perr;
    assign ovf_cnt    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl (FIFO, counters, baud
// switch sequencing, reset aborts). Rev 1.0
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int         DEPTH = 4;
    localparam int         QC    = 5;
    localparam logic [2:0] BD    = 3'd2;
    localparam int         CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b1;
    logic          cfg_baud_req = 1'b0;
    logic [2:0]    cfg_baud = 3'd0;
    logic          cfg_baud_ack, rx_en;
    logic [2:0]    baud_select;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_ferror = 1'b0, rx_perror = 1'b0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] fifo_count;
    logic [7:0]    ferror_cnt, perror_cnt, ovf_cnt;
`ifdef UART_RX_CTRL_ERRFLAG_EN
    logic [1:0]    out_err;
`endif

    uart_rx_ctrl #(.DEPTH(DEPTH), .QUIESCE_CYCLES(QC), .BAUD_DEFAULT(BD)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_baud_req(cfg_baud_req), .cfg_baud(cfg_baud), .cfg_baud_ack(cfg_baud_ack),
        .rx_en(rx_en), .baud_select(baud_select),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ferror(rx_ferror), .rx_perror(rx_perror),
`ifdef UART_RX_CTRL_ERRFLAG_EN
        .out_err(out_err),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .ferror_cnt(ferror_cnt), .perror_cnt(perror_cnt),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int         n_vec = 0, n_err = 0;
    logic [9:0] sb[$];
    int         exp_fe = 0, exp_pe = 0, exp_ovf = 0;
    logic [9:0] mon_exp;

    // occupancy follows the model every cycle; popped heads are compared in order
    always @(negedge clk) begin
        if (reset) begin
            n_vec++;
            if (out_valid !== (sb.size() != 0) || fifo_count !== CW'(sb.size())) begin
                n_err++;
                $display("FAIL occupancy: out_valid=%0b fifo_count=%0d, expected %0b / %0d",
                         out_valid, fifo_count, sb.size() != 0, sb.size());
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                mon_exp = sb.pop_front();
                n_vec++;
                if (out_data !== mon_exp[7:0]) begin
                    n_err++;
                    $display("FAIL pop_data: got %02h expected %02h", out_data, mon_exp[7:0]);
                end
`ifdef UART_RX_CTRL_ERRFLAG_EN
                n_vec++;
                if (out_err !== mon_exp[9:8]) begin
                    n_err++;
                    $display("FAIL pop_err: got %02b expected %02b", out_err, mon_exp[9:8]);
                end
`endif
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fe, input logic pe);
        bit full_before, will_pop, keep;
        full_before = (sb.size() == DEPTH);
        will_pop    = out_ready && (sb.size() != 0);
`ifdef UART_RX_CTRL_ERRFLAG_EN
        keep = 1'b1;
`else
        keep = !fe && !pe;
`endif
        rx_data = d; rx_ferror = fe; rx_perror = pe; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; rx_ferror = 1'b0; rx_perror = 1'b0;
        if (fe && exp_fe < 255) exp_fe++;
        if (pe && exp_pe < 255) exp_pe++;
        if (keep) begin
            if (!full_before || will_pop) sb.push_back({pe, fe, d});
            else if (exp_ovf < 255)       exp_ovf++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1;
        tick(3);
        @(negedge clk);
        n_vec++;
        if (rx_en !== 1'b0 || cfg_baud_ack !== 1'b0 || baud_select !== BD) begin
            n_err++;
            $display("FAIL reset_ctrl: rx_en=%0b ack=%0b baud=%0d, expected 0/0/%0d",
                     rx_en, cfg_baud_ack, baud_select, BD);
        end
        n_vec++;
        if (fifo_count !== '0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            ferror_cnt !== 8'd0 || perror_cnt !== 8'd0 || ovf_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_fifo: count=%0d valid=%0b data=%02h fe=%0d pe=%0d ovf=%0d, expected all 0",
                     fifo_count, out_valid, out_data, ferror_cnt, perror_cnt, ovf_cnt);
        end
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_vec++;
        if (rx_en !== 1'b0) begin
            n_err++;
            $display("FAIL release_rx_en0: got %0b expected 0", rx_en);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (rx_en !== 1'b1) begin
            n_err++;
            $display("FAIL release_rx_en1: got %0b expected 1", rx_en);
        end
    endtask

    task automatic test_stream();
        logic [7:0] v[3];
        v = '{8'h55, 8'hA3, 8'hFF};
        out_ready = 1'b1;
        tick();
        foreach (v[i]) begin
            send_byte(v[i], 1'b0, 1'b0);
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== v[i]) begin
                n_err++;
                $display("FAIL stream_latency: valid=%0b data=%02h expected 1/%02h",
                         out_valid, out_data, v[i]);
            end
            tick();
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (fifo_count !== '0) begin
            n_err++;
            $display("FAIL stream_empty: count=%0d expected 0", fifo_count);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            send_byte(8'(8'h10 + i), 1'b0, 1'b0);
            tick();
        end
        @(negedge clk);
        n_vec++;
        if (fifo_count !== CW'(DEPTH) || ovf_cnt !== 8'(exp_ovf) || exp_ovf != 2) begin
            n_err++;
            $display("FAIL overflow: count=%0d ovf=%0d expected %0d/%0d (model ovf %0d)",
                     fifo_count, ovf_cnt, DEPTH, 2, exp_ovf);
        end
        tick();
        out_ready = 1'b1;
        send_byte(8'hC0, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (fifo_count !== CW'(DEPTH) || ovf_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL full_push_pop: count=%0d ovf=%0d expected %0d/2",
                     fifo_count, ovf_cnt, DEPTH);
        end
        tick();
        out_ready = 1'b1;
        tick(DEPTH + 2);
        @(negedge clk);
        n_vec++;
        if (fifo_count !== '0) begin
            n_err++;
            $display("FAIL overflow_drain: count=%0d expected 0", fifo_count);
        end
    endtask

    task automatic test_baud_switch();
        int low, acks;
        bit done;
        low = 0; acks = 0; done = 1'b0;
        tick();
        cfg_baud = 3'd5; cfg_baud_req = 1'b1;
        tick();
        cfg_baud_req = 1'b0;
        for (int k = 0; k < 4 * QC + 10 && !done; k++) begin
            @(negedge clk);
            if (baud_select !== BD) done = 1'b1;
            else begin
                if (rx_en === 1'b0)        low++;
                if (cfg_baud_ack === 1'b1) acks++;
            end
        end
        n_vec++;
        if (!done || low != QC || acks != 0) begin
            n_err++;
            $display("FAIL quiesce: switched=%0b low_cycles=%0d early_acks=%0d expected 1/%0d/0",
                     done, low, acks, QC);
        end
        n_vec++;
        if (baud_select !== 3'd5 || cfg_baud_ack !== 1'b1 || rx_en !== 1'b0) begin
            n_err++;
            $display("FAIL baud_apply: baud=%0d ack=%0b rx_en=%0b expected 5/1/0",
                     baud_select, cfg_baud_ack, rx_en);
        end
        @(negedge clk);
        n_vec++;
        if (baud_select !== 3'd5 || cfg_baud_ack !== 1'b0 || rx_en !== 1'b1) begin
            n_err++;
            $display("FAIL baud_resume: baud=%0d ack=%0b rx_en=%0b expected 5/0/1",
                     baud_select, cfg_baud_ack, rx_en);
        end
    endtask

    task automatic test_errors();
        out_ready = 1'b0;
        tick();
        send_byte(8'h12, 1'b1, 1'b0);
        tick();
        send_byte(8'h34, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        n_vec++;
        if (ferror_cnt !== 8'd1 || perror_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL err_counts: fe=%0d pe=%0d expected 1/1", ferror_cnt, perror_cnt);
        end
        n_vec++;
`ifdef UART_RX_CTRL_ERRFLAG_EN
        if (fifo_count !== CW'(2)) begin
            n_err++;
            $display("FAIL err_fifo: count=%0d expected 2", fifo_count);
        end
`else
        if (fifo_count !== '0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL err_fifo: count=%0d valid=%0b expected 0/0", fifo_count, out_valid);
        end
`endif
        tick();
        out_ready = 1'b1;
        tick(3);
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
            tick();
        end
        @(negedge clk);
        n_vec++;
        if (ferror_cnt !== 8'hFF || ferror_cnt !== 8'(exp_fe) || perror_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL saturate: fe=%0d pe=%0d expected 255/1", ferror_cnt, perror_cnt);
        end
    endtask

    task automatic test_drain_disable();
        bit seen;
        seen = 1'b0;
        tick();
        cfg_baud = 3'd6; cfg_baud_req = 1'b1;
        tick();
        cfg_baud_req = 1'b0;
        tick(2);
        enable = 1'b0;
        for (int k = 0; k < 4 * QC + 10 && !seen; k++) begin
            @(negedge clk);
            if (cfg_baud_ack === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen || baud_select !== 3'd6) begin
            n_err++;
            $display("FAIL drain_disable_baud: ack_seen=%0b baud=%0d expected 1/6", seen, baud_select);
        end
        tick(3);
        @(negedge clk);
        n_vec++;
        if (rx_en !== 1'b0 || cfg_baud_ack !== 1'b0) begin
            n_err++;
            $display("FAIL drain_disable_off: rx_en=%0b ack=%0b expected 0/0", rx_en, cfg_baud_ack);
        end
        tick();
        enable = 1'b1;
        tick(3);
        @(negedge clk);
        n_vec++;
        if (rx_en !== 1'b1) begin
            n_err++;
            $display("FAIL reenable: rx_en=%0b expected 1", rx_en);
        end
    endtask

    task automatic test_reset_drain();
        int acks;
        acks = 0;
        tick();
        cfg_baud = 3'd7; cfg_baud_req = 1'b1;
        tick();
        cfg_baud_req = 1'b0;
        tick(2);
        reset = 1'b0;
        sb.delete();
        exp_fe = 0; exp_pe = 0; exp_ovf = 0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (baud_select !== BD || rx_en !== 1'b0 || cfg_baud_ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_drain_ctrl: baud=%0d rx_en=%0b ack=%0b expected %0d/0/0",
                     baud_select, rx_en, cfg_baud_ack, BD);
        end
        n_vec++;
        if (fifo_count !== '0 || out_data !== 8'h00 || ferror_cnt !== 8'd0 ||
            perror_cnt !== 8'd0 || ovf_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_drain_state: count=%0d data=%02h fe=%0d pe=%0d ovf=%0d expected all 0",
                     fifo_count, out_data, ferror_cnt, perror_cnt, ovf_cnt);
        end
        for (int k = 0; k < QC + 4; k++) begin
            @(negedge clk);
            if (cfg_baud_ack === 1'b1 || baud_select !== BD) acks++;
        end
        n_vec++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL reset_drain_abort: %0d cycles with ack or baud change, expected 0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_baud_switch();
        test_errors();
        test_saturate();
        test_drain_disable();
        test_reset_drain();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_left: %0d entries never delivered, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Controller between the UART receiver and its consumer.
- Sequences the receiver enable and owns baud_select; a baud change is applied only after the receiver has been quiesced for a set number of cycles.
- Buffers received bytes in a FIFO with a valid/ready handshake and keeps saturating error and overflow counters.
- Instantiated next to uart_receiver inside the UART top level; all its inputs are already synchronous to clk.

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of 2, 2..64.
- QUIESCE_CYCLES, 16, clk cycles rx_en is held low before baud_select changes; must be 1..65535.
- BAUD_DEFAULT, 3'd0, baud_select value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  software run request.
- cfg_baud_req  in  1  level request to change baud rate.
- cfg_baud  in  3  new baud code, sampled in SWITCH.
- cfg_baud_ack  out  1  one-cycle pulse when the new baud is applied.
- rx_en  out  1  drives receiver Rx_EN.
- baud_select  out  3  drives receiver baud_select.
- rx_valid  in  1  receiver Rx_VALID.
- rx_data  in  8  receiver Rx_DATA.
- rx_ferror  in  1  receiver Rx_FERROR.
- rx_perror  in  1  receiver Rx_PERROR.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head byte.
- fifo_count  out  log2(DEPTH)+1  current occupancy.
- ferror_cnt  out  8  saturating framing-error count.
- perror_cnt  out  8  saturating parity-error count.
- ovf_cnt  out  8  saturating dropped-byte count.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to OFF.
  - rx_en=0, baud_select=BAUD_DEFAULT, cfg_baud_ack=0.
  - FIFO is emptied (out_valid=0, fifo_count=0, out_data=0).
  - All counters are 0 and the edge-detect registers are cleared.
  - Reset asserted mid-frame or mid-switch aborts immediately. No partial baud change is kept.
- States:
  - OFF: rx_en=0. Go to RUN when enable=1.
  - RUN: rx_en=1.
    - enable=0 goes to OFF.
    - Otherwise cfg_baud_req=1 goes to DRAIN and loads the quiesce counter with QUIESCE_CYCLES.
    - enable=0 takes priority over cfg_baud_req.
  - DRAIN: rx_en=0 and the counter decrements each cycle. Go to SWITCH when it reaches 1.
  - SWITCH (one cycle):
    - baud_select<=cfg_baud and cfg_baud_ack=1.
    - Next state is RUN if enable=1, else OFF.
- rx_en is registered and changes on the cycle after the state transition.
- Byte capture:
  - A capture event is the rising edge of rx_valid (rx_valid=1 while the registered previous value is 0).
  - rx_ferror and rx_perror are sampled in the same cycle.
  - If either error is set, the byte is not pushed. The matching counter(s) increment, saturating at 255.
  - Events are accepted in any state; bytes still in flight while in DRAIN are kept.
- FIFO:
  - Push-to-out_valid latency is 1 cycle. out_data is the registered head.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop while full: both happen and the count is unchanged.
  - Push while full without a pop: the byte is dropped and ovf_cnt increments (saturating).
  - Push and pop while empty: no pop, because out_valid=0.
  - Read and write pointers wrap modulo DEPTH.
- Counters never wrap. They hold at 255 until reset.

Optional Feature:
- Macro: UART_RX_CTRL_ERRFLAG_EN.
- Enabled:
  - Errored bytes are pushed like good bytes. The FIFO is 10 bits wide.
  - An added port out_err (out, 2 bits, {perror, ferror}) accompanies out_data.
  - Error counters still increment.
- Disabled: errored bytes are dropped, there is no out_err port, and the FIFO is 8 bits wide.

Test Plan:
- Reset with enable=1, then release → rx_en=0 for the cycle after release and 1 the cycle after that; baud_select=BAUD_DEFAULT; fifo_count=0.
- Three rx_valid pulses with 0x55, 0xA3, 0xFF and out_ready=1 → out_data sequence 0x55, 0xA3, 0xFF, each out_valid one cycle after its push; fifo_count returns to 0.
- out_ready=0, DEPTH+2 good bytes → fifo_count=DEPTH, ovf_cnt=2; next a push and pop in the same cycle → count stays DEPTH and ovf_cnt stays 2.
- cfg_baud_req=1 with cfg_baud=3'd5 in RUN → rx_en low for exactly QUIESCE_CYCLES cycles, then baud_select=5 with a one-cycle cfg_baud_ack, then rx_en=1.
- Pulses with rx_ferror=1 (0x12) and rx_perror=1 (0x34) → ferror_cnt=1, perror_cnt=1, FIFO empty. With UART_RX_CTRL_ERRFLAG_EN: the FIFO holds 0x12 with out_err=01 and 0x34 with out_err=10.
- 300 framing errors → ferror_cnt holds 255; enable dropped during DRAIN → state OFF after SWITCH, baud updated; reset during DRAIN → baud_select=BAUD_DEFAULT.
